ball_motion: RTL and testbench
==============================

Name: ball_motion

Overview:
- Upstream stage of the brick/score block in the breakout game.
- Owns the ball position and direction on the 16x16 cell grid, stepped at a slow game rate.
- Bounces the ball off the walls, the paddle, and live bricks using the brick map fed back from the score stage.
- Tracks lives and serve/launch.
- Outputs Ball_rowIndex / Ball_colIndex / Ball_direction directly drive the brick/score stage.

Parameters:
- STEP_DIV, 25000000: clock cycles per ball step (50 MHz -> 2 Hz).
- PADDLE_W, 4: paddle width in cells, range 1..8.
- LIVES, 3: lives at reset, range 1..7.

Ports:
- clock  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- paddle_col  in  4  leftmost paddle column; paddle sits on row 15.
- launch  in  1  level; serves the ball when sampled high in SERVE.
- Bricks  in  56  brick map from the score stage; bit r*8+(c>>1) = brick at row r (0..6), column pair c.
- Ball_rowIndex  out  4  ball row, 0 = top.
- Ball_colIndex  out  4  ball column, 0 = left.
- Ball_direction  out  2  bit1 = vertical (1 = down), bit0 = horizontal (1 = right).
- lives  out  3  remaining lives.
- in_play  out  1  high in MOVE.
- game_over  out  1  high in OVER.
- step  out  1  one-cycle pulse on each ball step tick.

Behaviour:
- Reset (async, active-low):
  - state SERVE; row 14, col 0, dir 2'b01 (up-right).
  - lives = LIVES; in_play = 0; game_over = 0; step = 0; divider = 0.
- Divider:
  - Counts 0..STEP_DIV-1 only in MOVE and LOST; held at 0 in other states.
  - step pulses in the cycle the divider wraps.
- SERVE:
  - Every clock: row = 14, col = paddle_col, dir = 01.
  - launch = 1 -> MOVE on the next clock.
- MOVE, on each step, resolved in this order from the current state:
  1. Horizontal wall: col = 0 and moving left, or col = 15 and moving right -> flip bit0.
  2. Top wall: row = 0 and moving up -> flip bit1.
  3. Target cell: target col = col ± 1 and target row = row ± 1, using the resolved direction.
  4. Paddle: if row = 14, moving down, and target col lies in [paddle_col, paddle_col+PADDLE_W-1] (5-bit compare, no wrap) -> set bit1 = 0, ball does not move this step.
  5. Miss: row = 14, moving down, paddle not hit -> move to row 15, enter LOST.
  6. Brick: target row < 7 and Bricks[target row*8 + target col>>1] = 1 -> move into the target cell and flip bit1. Brick removal belongs to the score stage.
  7. Otherwise move to the target cell.
- LOST:
  - On entry, lives decrements by 1, saturating at 0.
  - Ball holds at row 15 for one step period.
  - At the next step: lives = 0 -> OVER, else SERVE.
- OVER:
  - game_over = 1; ball frozen; launch ignored.
  - Left only by reset.
- Corner (col 0 or 15 at row 0): both flips apply in the same step.
- launch is ignored outside SERVE.
- paddle_col changes take effect combinationally at the next step decision.
- Reset mid-step: divider and state are cleared immediately; no partial move.

Optional Feature:
- Macro: BALL_SPEEDUP_EN.
- Defined:
  - A 4-bit paddle-hit counter increments on each paddle bounce.
  - Every 8th hit raises speed level 0 -> 1 -> 2 (saturating).
  - Step period = STEP_DIV >> level.
  - Level and counter clear on entering SERVE or on reset.
- Not defined: step period is fixed at STEP_DIV and no counter exists.

Test Plan (STEP_DIV = 4, PADDLE_W = 4, LIVES = 3):
- Reset, then paddle_col = 5 -> row 14, col 5, dir 01, lives 3, in_play 0, game_over 0.
- Launch at col 5 with Bricks = 0 -> step every 4 clocks; after step 1: row 13, col 6; after step 4: row 10, col 9, dir 01.
- Launch at col 5 with Bricks = all ones -> after step 7: row 7, col 12; after step 8: row 6, col 13, dir 11 (bit 54 was set).
- Ball at row 0, col 15, dir 01 -> next step: row 1, col 14, dir 10.
- Ball at row 14, col 3, dir 11, paddle_col = 10 -> row 15, lives 2; one step later SERVE (row 14, col 10).
- Three consecutive misses -> lives 0, game_over 1; launch held high -> ball stays frozen until reset.

Source files
------------

// File: rtl/ball_motion.sv
// Ball position/direction engine for the breakout game: wall, paddle and brick bounces, lives and serve.
// Optional BALL_SPEEDUP_EN shortens the step period as paddle hits accumulate.
module ball_motion #(
    parameter int STEP_DIV = 25000000,
    parameter int PADDLE_W = 4,
    parameter int LIVES    = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  paddle_col,
    input  logic        launch,
    input  logic [55:0] Bricks,
    output logic [3:0]  Ball_rowIndex,
    output logic [3:0]  Ball_colIndex,
    output logic [1:0]  Ball_direction,
    output logic [2:0]  lives,
    output logic        in_play,
    output logic        game_over,
    output logic        step
);

    typedef enum logic [1:0] {ST_SERVE, ST_MOVE, ST_LOST, ST_OVER} state_t;

    localparam int DIV_W = $clog2(STEP_DIV) + 1;

    state_t             r_state, w_state_nx;
    logic [DIV_W-1:0]   r_div, w_period;
    logic [3:0]         r_row, r_col, w_row_nx, w_col_nx;
    logic [1:0]         r_dir, w_dir_nx, w_rdir;
    logic [2:0]         r_lives, w_lives_nx;
    logic               r_in_play, r_game_over, r_step;
    logic               w_counting, w_wrap, w_hflip, w_vflip;
    logic [3:0]         w_trow, w_tcol;
    logic [4:0]         w_pad_lo, w_pad_hi;
    logic               w_pad_in, w_brick, w_pad_hit;

    function automatic logic [5:0] brick_idx(input logic [3:0] row, input logic [3:0] col);
        return {row[2:0], col[3:1]};
    endfunction

`ifdef BALL_SPEEDUP_EN
    logic [3:0]       r_hits;
    logic [1:0]       r_level;
    logic [DIV_W-1:0] w_shifted;

    assign w_shifted = DIV_W'(STEP_DIV) >> r_level;
    assign w_period  = (w_shifted == DIV_W'(0)) ? DIV_W'(1) : w_shifted;

    // Paddle-hit counter and speed level; both restart whenever a serve begins
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hits  <= 4'd0;
            r_level <= 2'd0;
        end else if (w_state_nx == ST_SERVE) begin
            r_hits  <= 4'd0;
            r_level <= 2'd0;
        end else if (w_pad_hit) begin
            r_hits <= r_hits + 4'd1;
            if ((r_hits[2:0] == 3'd7) && (r_level != 2'd2)) begin
                r_level <= r_level + 2'd1;
            end else begin
                r_level <= r_level;
            end
        end else begin
            r_hits  <= r_hits;
            r_level <= r_level;
        end
    end
`else
    assign w_period = DIV_W'(STEP_DIV);
`endif

    assign w_counting = (r_state == ST_MOVE) || (r_state == ST_LOST);
    // >= rather than == so a period that shrinks mid-count still wraps
    assign w_wrap     = w_counting && (r_div >= (w_period - DIV_W'(1)));

    assign w_hflip  = ((r_col == 4'd0) && !r_dir[0]) || ((r_col == 4'd15) && r_dir[0]);
    assign w_vflip  = (r_row == 4'd0) && !r_dir[1];
    assign w_rdir   = {r_dir[1] ^ w_vflip, r_dir[0] ^ w_hflip};
    assign w_tcol   = w_rdir[0] ? (r_col + 4'd1) : (r_col - 4'd1);
    assign w_trow   = w_rdir[1] ? (r_row + 4'd1) : (r_row - 4'd1);
    assign w_pad_lo = {1'b0, paddle_col};
    assign w_pad_hi = w_pad_lo + 5'(PADDLE_W - 1);
    assign w_pad_in = ({1'b0, w_tcol} >= w_pad_lo) && ({1'b0, w_tcol} <= w_pad_hi);
    assign w_brick  = (w_trow < 4'd7) && Bricks[brick_idx(w_trow, w_tcol)];

    // Next-state and next ball position
    always_comb begin
        w_state_nx = r_state;
        w_row_nx   = r_row;
        w_col_nx   = r_col;
        w_dir_nx   = r_dir;
        w_lives_nx = r_lives;
        w_pad_hit  = 1'b0;
        case (r_state)
            ST_SERVE: begin
                w_row_nx = 4'd14;
                w_col_nx = paddle_col;
                w_dir_nx = 2'b01;
                if (launch) begin
                    w_state_nx = ST_MOVE;
                end else begin
                    w_state_nx = ST_SERVE;
                end
            end
            ST_MOVE: begin
                if (!w_wrap) begin
                    w_state_nx = ST_MOVE;
                end else if ((r_row == 4'd14) && w_rdir[1]) begin
                    if (w_pad_in) begin
                        w_dir_nx  = {1'b0, w_rdir[0]};
                        w_pad_hit = 1'b1;
                    end else begin
                        w_row_nx   = 4'd15;
                        w_dir_nx   = w_rdir;
                        w_state_nx = ST_LOST;
                        w_lives_nx = (r_lives == 3'd0) ? 3'd0 : (r_lives - 3'd1);
                    end
                end else if (w_brick) begin
                    w_row_nx = w_trow;
                    w_col_nx = w_tcol;
                    w_dir_nx = {~w_rdir[1], w_rdir[0]};
                end else begin
                    w_row_nx = w_trow;
                    w_col_nx = w_tcol;
                    w_dir_nx = w_rdir;
                end
            end
            ST_LOST: begin
                if (!w_wrap) begin
                    w_state_nx = ST_LOST;
                end else if (r_lives == 3'd0) begin
                    w_state_nx = ST_OVER;
                end else begin
                    w_state_nx = ST_SERVE;
                    w_row_nx   = 4'd14;
                    w_col_nx   = paddle_col;
                    w_dir_nx   = 2'b01;
                end
            end
            ST_OVER: begin
                w_state_nx = ST_OVER;
            end
            default: begin
                w_state_nx = ST_SERVE;
            end
        endcase
    end

    // State, divider and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_SERVE;
            r_div       <= DIV_W'(0);
            r_row       <= 4'd14;
            r_col       <= 4'd0;
            r_dir       <= 2'b01;
            r_lives     <= 3'(LIVES);
            r_in_play   <= 1'b0;
            r_game_over <= 1'b0;
            r_step      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_div       <= (w_counting && !w_wrap) ? (r_div + DIV_W'(1)) : DIV_W'(0);
            r_row       <= w_row_nx;
            r_col       <= w_col_nx;
            r_dir       <= w_dir_nx;
            r_lives     <= w_lives_nx;
            r_in_play   <= (w_state_nx == ST_MOVE);
            r_game_over <= (w_state_nx == ST_OVER);
            r_step      <= w_wrap;
        end
    end

    assign Ball_rowIndex  = r_row;
    assign Ball_colIndex  = r_col;
    assign Ball_direction = r_dir;
    assign lives          = r_lives;
    assign in_play        = r_in_play;
    assign game_over      = r_game_over;
    assign step           = r_step;

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion with STEP_DIV=4, PADDLE_W=4, LIVES=3.
module tb_ball_motion;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  paddle_col = 4'd0;
    logic        launch = 1'b0;
    logic [55:0] Bricks = 56'd0;
    logic [3:0]  Ball_rowIndex, Ball_colIndex;
    logic [1:0]  Ball_direction;
    logic [2:0]  lives;
    logic        in_play, game_over, step;

    int checks = 0;
    int errors = 0;
    logic [9:0] sb[$];

    ball_motion #(.STEP_DIV(4), .PADDLE_W(4), .LIVES(3)) dut (
        .clock(clock), .reset(reset), .paddle_col(paddle_col), .launch(launch),
        .Bricks(Bricks), .Ball_rowIndex(Ball_rowIndex), .Ball_colIndex(Ball_colIndex),
        .Ball_direction(Ball_direction), .lives(lives), .in_play(in_play),
        .game_over(game_over), .step(step)
    );

    always #5 clock = ~clock;

    task automatic wait_step(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (step === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset(input logic [3:0] pcol, input logic [55:0] bricks);
        @(negedge clock);
        reset = 1'b0; launch = 1'b0; paddle_col = pcol; Bricks = bricks;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic do_launch();
        launch = 1'b1;
        @(negedge clock);
        launch = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b0; paddle_col = 4'd5; Bricks = 56'd0; launch = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if ({Ball_rowIndex, Ball_colIndex, Ball_direction, lives, in_play, game_over, step}
            !== {4'd14, 4'd0, 2'b01, 3'd3, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got r%0d c%0d d%b l%0d p%b g%b s%b exp r14 c0 d01 l3 p0 g0 s0",
                     Ball_rowIndex, Ball_colIndex, Ball_direction, lives, in_play, game_over, step);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({Ball_rowIndex, Ball_colIndex, Ball_direction, lives, in_play, game_over}
            !== {4'd14, 4'd5, 2'b01, 3'd3, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL serve_follow got r%0d c%0d d%b l%0d p%b g%b exp r14 c5 d01 l3 p0 g0",
                     Ball_rowIndex, Ball_colIndex, Ball_direction, lives, in_play, game_over);
        end
    endtask

    task automatic test_free_flight();
        logic [9:0] e_pos;
        bit got;
        do_reset(4'd5, 56'd0);
        do_launch();
        checks++;
        if (in_play !== 1'b1) begin
            errors++;
            $display("FAIL in_play got %b exp 1", in_play);
        end
        for (int k = 1; k <= 4; k++) sb.push_back({4'(14 - k), 4'(5 + k), 2'b01});
        for (int n = 1; sb.size() > 0; n++) begin
            e_pos = sb.pop_front();
            wait_step(got);
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL free_step_timeout step %0d", n);
            end else if ({Ball_rowIndex, Ball_colIndex, Ball_direction} !== e_pos) begin
                errors++;
                $display("FAIL free_traj step %0d got %h exp %h", n,
                         {Ball_rowIndex, Ball_colIndex, Ball_direction}, e_pos);
            end
        end
    endtask

    task automatic test_brick_and_paddle();
        logic [9:0] e_pos;
        bit got;
        do_reset(4'd5, {56{1'b1}});
        do_launch();
        for (int k = 1; k <= 7; k++) sb.push_back({4'(14 - k), 4'(5 + k), 2'b01});
        sb.push_back({4'd6, 4'd13, 2'b11});
        for (int j = 1; j <= 2; j++) sb.push_back({4'(6 + j), 4'(13 + j), 2'b11});
        for (int j = 1; j <= 6; j++) sb.push_back({4'(8 + j), 4'(15 - j), 2'b10});
        sb.push_back({4'd14, 4'd9, 2'b00});
        for (int n = 1; sb.size() > 0; n++) begin
            e_pos = sb.pop_front();
            wait_step(got);
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL brick_step_timeout step %0d", n);
            end else if ({Ball_rowIndex, Ball_colIndex, Ball_direction} !== e_pos) begin
                errors++;
                $display("FAIL brick_traj step %0d got %h exp %h", n,
                         {Ball_rowIndex, Ball_colIndex, Ball_direction}, e_pos);
            end
        end
    endtask

    // Serve at col 1, move paddle to col 10, ride the corner bounce down to a miss
    task automatic play_miss(input int exp_lives);
        logic [9:0] e_pos;
        bit got;
        paddle_col = 4'd1;
        @(negedge clock);
        do_launch();
        paddle_col = 4'd10;
        for (int k = 1; k <= 14; k++) sb.push_back({4'(14 - k), 4'(1 + k), 2'b01});
        sb.push_back({4'd1, 4'd14, 2'b10});
        for (int j = 1; j <= 13; j++) sb.push_back({4'(1 + j), 4'(14 - j), 2'b10});
        sb.push_back({4'd15, 4'd1, 2'b10});
        if (exp_lives > 0) sb.push_back({4'd14, 4'd10, 2'b01});
        else sb.push_back({4'd15, 4'd1, 2'b10});
        for (int n = 1; sb.size() > 0; n++) begin
            e_pos = sb.pop_front();
            wait_step(got);
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL miss_step_timeout step %0d", n);
            end else if ({Ball_rowIndex, Ball_colIndex, Ball_direction} !== e_pos) begin
                errors++;
                $display("FAIL miss_traj step %0d got %h exp %h", n,
                         {Ball_rowIndex, Ball_colIndex, Ball_direction}, e_pos);
            end
            if (n == 29) begin
                checks++;
                if ({lives, in_play} !== {3'(exp_lives), 1'b0}) begin
                    errors++;
                    $display("FAIL lost_lives got l%0d p%b exp l%0d p0", lives, in_play, exp_lives);
                end
            end
        end
        checks++;
        if (game_over !== (exp_lives == 0)) begin
            errors++;
            $display("FAIL game_over_flag got %b exp %b", game_over, (exp_lives == 0));
        end
    endtask

    task automatic test_corner_and_miss();
        do_reset(4'd1, 56'd0);
        play_miss(2);
    endtask

    task automatic test_game_over();
        bit got;
        play_miss(1);
        play_miss(0);
        launch = 1'b1;
        wait_step(got);
        wait_step(got);
        checks++;
        if (got) begin
            errors++;
            $display("FAIL over_no_step got step exp none");
        end
        checks++;
        if ({Ball_rowIndex, Ball_colIndex, Ball_direction, lives, in_play, game_over}
            !== {4'd15, 4'd1, 2'b10, 3'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL over_frozen got r%0d c%0d d%b l%0d p%b g%b exp r15 c1 d10 l0 p0 g1",
                     Ball_rowIndex, Ball_colIndex, Ball_direction, lives, in_play, game_over);
        end
        launch = 1'b0;
        do_reset(4'd7, 56'd0);
        checks++;
        if ({Ball_rowIndex, Ball_colIndex, lives, game_over} !== {4'd14, 4'd7, 3'd3, 1'b0}) begin
            errors++;
            $display("FAIL over_reset got r%0d c%0d l%0d g%b exp r14 c7 l3 g0",
                     Ball_rowIndex, Ball_colIndex, lives, game_over);
        end
    endtask

    task automatic test_reset_mid_move();
        do_reset(4'd5, 56'd0);
        do_launch();
        repeat (6) @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if ({Ball_rowIndex, Ball_colIndex, Ball_direction, in_play, step}
            !== {4'd14, 4'd0, 2'b01, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset got r%0d c%0d d%b p%b s%b exp r14 c0 d01 p0 s0",
                     Ball_rowIndex, Ball_colIndex, Ball_direction, in_play, step);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_free_flight();
        test_brick_and_paddle();
        test_corner_and_miss();
        test_game_over();
        test_reset_mid_move();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
